// File: rtl/pc_sequencer_mod_if.sv
// Next-PC sequencer bundle: pipeline status and redirect requests in,
// next PC, flush controls and status out.
interface pc_sequencer_mod_if #(
  parameter int N     = 10,
  parameter int CNT_W = 16
);
  logic [N-1:0]     pc_i;
  logic             stall_i;
  logic             jump_i;
  logic [31:0]      jump_target_i;
  logic             br_taken_i;
  logic [31:0]      br_target_i;
  logic             halt_i;
  logic [31:0]      next_pc_o;
  logic             flush_if_id_o;
  logic             flush_id_ex_o;
  logic             halted_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  // sequencer side
  modport master (
    input  pc_i, stall_i, jump_i, jump_target_i, br_taken_i, br_target_i, halt_i,
    output next_pc_o, flush_if_id_o, flush_id_ex_o, halted_o, redirect_cnt_o
  );

  // pipeline / program-counter side
  modport slave (
    output pc_i, stall_i, jump_i, jump_target_i, br_taken_i, br_target_i, halt_i,
    input  next_pc_o, flush_if_id_o, flush_id_ex_o, halted_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_sequencer_mod.sv
// Next-PC controller: picks sequential / jump / branch / hold / halt PC,
// raises pipeline flushes after redirects and counts redirects.
//
// state | meaning
// BOOT  | first cycle after reset, next PC forced to 0
// RUN   | normal fetch, all redirect sources honoured
// FLUSH | bubble cycles after a taken branch, only branches honoured
// HALT  | PC frozen until reset
module pc_sequencer_mod #(
  parameter int N         = 10,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  pc_sequencer_mod_if.master bus
);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             fl_if_q, fl_if_d;
  logic             fl_ex_q, fl_ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic             redirect;
  logic [N-1:0]     npc;
  logic [N-1:0]     pc_inc;
  logic             unused_target_hi;

  // target bits above the PC width are meaningless and dropped
  assign unused_target_hi = ^{bus.jump_target_i[31:N], bus.br_target_i[31:N]};
  assign pc_inc = bus.pc_i + N'(1);

  // next-state, next PC and next flush values
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    fl_if_d  = 1'b0;
    fl_ex_d  = 1'b0;
    redirect = 1'b0;
    npc      = pc_inc;
    case (state_q)
      BOOT: begin
        npc     = '0;
        state_d = RUN;
      end
      RUN: begin
        if (bus.halt_i) begin
          npc     = bus.pc_i;
          state_d = HALT;
        end else if (bus.br_taken_i) begin
          npc      = bus.br_target_i[N-1:0];
          state_d  = FLUSH;
          fcnt_d   = FLUSH_LOAD;
          fl_if_d  = 1'b1;
          fl_ex_d  = 1'b1;
          redirect = 1'b1;
        end else if (bus.jump_i) begin
          npc      = bus.jump_target_i[N-1:0];
          fl_if_d  = 1'b1;
          redirect = 1'b1;
        end else if (bus.stall_i) begin
          npc = bus.pc_i;
        end
      end
      FLUSH: begin
        if (bus.br_taken_i) begin
          npc      = bus.br_target_i[N-1:0];
          fcnt_d   = FLUSH_LOAD;
          fl_if_d  = 1'b1;
          fl_ex_d  = 1'b1;
          redirect = 1'b1;
        end else if (fcnt_q == '0) begin
          state_d = RUN;
        end else begin
          fcnt_d  = fcnt_q - 1'b1;
          fl_if_d = 1'b1;
          fl_ex_d = 1'b1;
        end
      end
      HALT: begin
        npc = bus.pc_i;
      end
      default: begin
        npc     = '0;
        state_d = BOOT;
      end
    endcase
  end

  // state, flush timer and registered flush outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      fcnt_q  <= '0;
      fl_if_q <= 1'b0;
      fl_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      fl_if_q <= fl_if_d;
      fl_ex_q <= fl_ex_d;
    end
  end

  // saturating redirect counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (redirect && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.next_pc_o      = {{(32-N){1'b0}}, npc};
  assign bus.flush_if_id_o  = fl_if_q;
  assign bus.flush_id_ex_o  = fl_ex_q;
  assign bus.halted_o       = (state_q == HALT);
  assign bus.redirect_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_sequencer_mod.sv
module tb_pc_sequencer_mod;
  localparam int N         = 10;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int MASK      = (1 << N) - 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_mod_if #(.N(N), .CNT_W(CNT_W)) bus ();

  pc_sequencer_mod #(.N(N), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_i       = 1'b0;
    bus.jump_i        = 1'b0;
    bus.jump_target_i = '0;
    bus.br_taken_i    = 1'b0;
    bus.br_target_i   = '0;
    bus.halt_i        = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.pc_i = 10'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.next_pc_o !== 32'd0) begin errors++; $display("FAIL reset_next_pc got %0d want 0", bus.next_pc_o); end
    checks++; if (bus.flush_if_id_o !== 1'b0) begin errors++; $display("FAIL reset_flush_if got %b want 0", bus.flush_if_id_o); end
    checks++; if (bus.flush_id_ex_o !== 1'b0) begin errors++; $display("FAIL reset_flush_ex got %b want 0", bus.flush_id_ex_o); end
    checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted_o); end
    checks++; if (bus.redirect_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.redirect_cnt_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.next_pc_o !== 32'd0) begin errors++; $display("FAIL boot_next_pc got %0d want 0", bus.next_pc_o); end
    tick();
    bus.pc_i = 10'd0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (bus.next_pc_o !== 32'(i)) begin errors++; $display("FAIL seq_next_pc got %0d want %0d", bus.next_pc_o, i); end
      checks++; if ({bus.flush_if_id_o, bus.flush_id_ex_o} !== 2'b00) begin errors++; $display("FAIL seq_flush got %b want 00", {bus.flush_if_id_o, bus.flush_id_ex_o}); end
      checks++; if (bus.redirect_cnt_o !== 4'd0) begin errors++; $display("FAIL seq_cnt got %0d want 0", bus.redirect_cnt_o); end
      tick();
      bus.pc_i = 10'(i);
    end
  endtask

  task automatic test_wrap();
    bus.pc_i = 10'd1023;
    @(negedge clk);
    checks++; if (bus.next_pc_o !== 32'd0) begin errors++; $display("FAIL wrap_next_pc got %0d want 0", bus.next_pc_o); end
    tick();
    bus.pc_i = 10'd0;
  endtask

  task automatic test_branch();
    bus.pc_i = 10'd5;
    bus.br_taken_i = 1'b1;
    bus.br_target_i = 32'h4C8;
    @(negedge clk);
    checks++; if (bus.next_pc_o !== 32'hC8) begin errors++; $display("FAIL br_next_pc got %h want c8", bus.next_pc_o); end
    checks++; if (bus.flush_if_id_o !== 1'b0) begin errors++; $display("FAIL br_flush_early got %b want 0", bus.flush_if_id_o); end
    tick();
    idle_inputs();
    bus.pc_i = 10'hC8;
    for (int k = 0; k < FLUSH_CYC; k++) begin
      // wrong-path jump/stall during the bubble must be ignored
      bus.jump_i = 1'b1;
      bus.jump_target_i = 32'd300;
      bus.stall_i = 1'b1;
      @(negedge clk);
      checks++; if ({bus.flush_if_id_o, bus.flush_id_ex_o} !== 2'b11) begin errors++; $display("FAIL br_flush got %b want 11", {bus.flush_if_id_o, bus.flush_id_ex_o}); end
      checks++; if (bus.next_pc_o !== 32'(bus.pc_i) + 32'd1) begin errors++; $display("FAIL br_flush_next_pc got %0d want %0d", bus.next_pc_o, bus.pc_i + 1); end
      checks++; if (bus.redirect_cnt_o !== 4'd1) begin errors++; $display("FAIL br_cnt got %0d want 1", bus.redirect_cnt_o); end
      tick();
      bus.pc_i = bus.pc_i + 10'd1;
    end
    idle_inputs();
    @(negedge clk);
    checks++; if ({bus.flush_if_id_o, bus.flush_id_ex_o} !== 2'b00) begin errors++; $display("FAIL br_flush_end got %b want 00", {bus.flush_if_id_o, bus.flush_id_ex_o}); end
    checks++; if (bus.redirect_cnt_o !== 4'd1) begin errors++; $display("FAIL br_cnt_end got %0d want 1", bus.redirect_cnt_o); end
    tick();
  endtask

  task automatic test_jump_stall();
    bus.pc_i = 10'd7;
    bus.jump_i = 1'b1;
    bus.stall_i = 1'b1;
    bus.jump_target_i = 32'd40;
    @(negedge clk);
    checks++; if (bus.next_pc_o !== 32'd40) begin errors++; $display("FAIL jmp_next_pc got %0d want 40", bus.next_pc_o); end
    tick();
    idle_inputs();
    bus.pc_i = 10'd40;
    @(negedge clk);
    checks++; if ({bus.flush_if_id_o, bus.flush_id_ex_o} !== 2'b10) begin errors++; $display("FAIL jmp_flush got %b want 10", {bus.flush_if_id_o, bus.flush_id_ex_o}); end
    checks++; if (bus.redirect_cnt_o !== 4'd2) begin errors++; $display("FAIL jmp_cnt got %0d want 2", bus.redirect_cnt_o); end
    tick();
    bus.pc_i = 10'd41;
    bus.stall_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.flush_if_id_o !== 1'b0) begin errors++; $display("FAIL jmp_flush_end got %b want 0", bus.flush_if_id_o); end
    checks++; if (bus.next_pc_o !== 32'd41) begin errors++; $display("FAIL stall_next_pc got %0d want 41", bus.next_pc_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_jump_and_branch();
    bus.pc_i = 10'd50;
    bus.jump_i = 1'b1;
    bus.br_taken_i = 1'b1;
    bus.br_target_i = 32'd100;
    bus.jump_target_i = 32'd200;
    @(negedge clk);
    checks++; if (bus.next_pc_o !== 32'd100) begin errors++; $display("FAIL jb_next_pc got %0d want 100", bus.next_pc_o); end
    tick();
    idle_inputs();
    bus.pc_i = 10'd100;
    @(negedge clk);
    checks++; if (bus.redirect_cnt_o !== 4'd3) begin errors++; $display("FAIL jb_cnt got %0d want 3", bus.redirect_cnt_o); end
    checks++; if ({bus.flush_if_id_o, bus.flush_id_ex_o} !== 2'b11) begin errors++; $display("FAIL jb_flush got %b want 11", {bus.flush_if_id_o, bus.flush_id_ex_o}); end
    repeat (FLUSH_CYC) tick();
    @(negedge clk);
    checks++; if (bus.flush_id_ex_o !== 1'b0) begin errors++; $display("FAIL jb_flush_end got %b want 0", bus.flush_id_ex_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.pc_i = 10'd0;
    for (int i = 0; i < 20; i++) begin
      bus.jump_i = 1'b1;
      bus.jump_target_i = 32'(i * 3);
      @(negedge clk);
      checks++; if (bus.next_pc_o !== 32'(i * 3)) begin errors++; $display("FAIL b2b_next_pc got %0d want %0d", bus.next_pc_o, i * 3); end
      if (i > 0) begin
        checks++; if (bus.flush_if_id_o !== 1'b1) begin errors++; $display("FAIL b2b_flush got %b want 1", bus.flush_if_id_o); end
      end
      tick();
      bus.pc_i = 10'(i * 3);
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.redirect_cnt_o !== 4'(CNT_MAX)) begin errors++; $display("FAIL sat_cnt got %0d want %0d", bus.redirect_cnt_o, CNT_MAX); end
    tick();
  endtask

  task automatic test_random();
    bit   m_boot, m_halted, m_jflush;
    int   m_rem, m_cnt;
    logic [31:0] e_np;
    rst_n = 1'b0;
    idle_inputs();
    #2;
    rst_n = 1'b1;
    tick();
    bus.pc_i = 10'd0;
    m_boot = 0; m_halted = 0; m_jflush = 0; m_rem = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.halt_i        = ($urandom_range(0, 63) == 0);
      bus.br_taken_i    = ($urandom_range(0, 5) == 0);
      bus.jump_i        = ($urandom_range(0, 4) == 0);
      bus.stall_i       = ($urandom_range(0, 3) == 0);
      bus.br_target_i   = $urandom;
      bus.jump_target_i = $urandom;
      @(negedge clk);
      if (m_boot) e_np = 0;
      else if (m_halted) e_np = 32'(bus.pc_i);
      else if (m_rem > 0) e_np = bus.br_taken_i ? (bus.br_target_i & MASK) : ((32'(bus.pc_i) + 1) & MASK);
      else if (bus.halt_i) e_np = 32'(bus.pc_i);
      else if (bus.br_taken_i) e_np = bus.br_target_i & MASK;
      else if (bus.jump_i) e_np = bus.jump_target_i & MASK;
      else if (bus.stall_i) e_np = 32'(bus.pc_i);
      else e_np = (32'(bus.pc_i) + 1) & MASK;
      checks++; if (bus.next_pc_o !== e_np) begin errors++; $display("FAIL rnd_next_pc cyc %0d got %0d want %0d", cyc, bus.next_pc_o, e_np); end
      checks++; if (bus.flush_if_id_o !== ((m_rem > 0) || m_jflush)) begin errors++; $display("FAIL rnd_flush_if cyc %0d got %b", cyc, bus.flush_if_id_o); end
      checks++; if (bus.flush_id_ex_o !== (m_rem > 0)) begin errors++; $display("FAIL rnd_flush_ex cyc %0d got %b", cyc, bus.flush_id_ex_o); end
      checks++; if (bus.halted_o !== m_halted) begin errors++; $display("FAIL rnd_halted cyc %0d got %b want %b", cyc, bus.halted_o, m_halted); end
      checks++; if (bus.redirect_cnt_o !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, bus.redirect_cnt_o, m_cnt); end
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.next_pc_o, bus.flush_if_id_o, bus.flush_id_ex_o, bus.halted_o, bus.redirect_cnt_o} !== '0) begin errors++; $display("FAIL rnd_async_reset cyc %0d outputs not cleared", cyc); end
        rst_n = 1'b1;
        tick();
        m_boot = 0; m_halted = 0; m_jflush = 0; m_rem = 0; m_cnt = 0;
        bus.pc_i = 10'd0;
      end else begin
        tick();
        if (m_boot) begin
          m_boot = 0;
        end else if (m_halted) begin
          m_halted = 1;
        end else if (m_rem > 0) begin
          m_jflush = 0;
          if (bus.br_taken_i) begin m_rem = FLUSH_CYC; m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX; end
          else m_rem = m_rem - 1;
        end else begin
          m_jflush = 0;
          if (bus.halt_i) m_halted = 1;
          else if (bus.br_taken_i) begin m_rem = FLUSH_CYC; m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX; end
          else if (bus.jump_i) begin m_jflush = 1; m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX; end
        end
        bus.pc_i = ($urandom_range(0, 15) == 0) ? 10'($urandom) : e_np[N-1:0];
      end
    end
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    bus.pc_i = 10'd0;
  endtask

  task automatic test_reset_mid_flush();
    bus.pc_i = 10'd9;
    bus.br_taken_i = 1'b1;
    bus.br_target_i = 32'd77;
    tick();
    idle_inputs();
    bus.pc_i = 10'd77;
    #2;
    checks++; if (bus.flush_id_ex_o !== 1'b1) begin errors++; $display("FAIL mf_flush_pre got %b want 1", bus.flush_id_ex_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.flush_if_id_o, bus.flush_id_ex_o} !== 2'b00) begin errors++; $display("FAIL mf_flush got %b want 00", {bus.flush_if_id_o, bus.flush_id_ex_o}); end
    checks++; if (bus.redirect_cnt_o !== 4'd0) begin errors++; $display("FAIL mf_cnt got %0d want 0", bus.redirect_cnt_o); end
    checks++; if (bus.next_pc_o !== 32'd0) begin errors++; $display("FAIL mf_next_pc got %0d want 0", bus.next_pc_o); end
    rst_n = 1'b1;
    tick();
    bus.pc_i = 10'd0;
  endtask

  task automatic test_halt();
    bus.pc_i = 10'd12;
    bus.halt_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.next_pc_o !== 32'd12) begin errors++; $display("FAIL halt_next_pc got %0d want 12", bus.next_pc_o); end
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.halt_i        = $urandom_range(0, 1);
      bus.br_taken_i    = $urandom_range(0, 1);
      bus.jump_i        = $urandom_range(0, 1);
      bus.stall_i       = $urandom_range(0, 1);
      bus.br_target_i   = $urandom;
      bus.jump_target_i = $urandom;
      @(negedge clk);
      checks++; if (bus.next_pc_o !== 32'd12) begin errors++; $display("FAIL halt_hold got %0d want 12", bus.next_pc_o); end
      checks++; if (bus.halted_o !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", bus.halted_o); end
      checks++; if ({bus.flush_if_id_o, bus.flush_id_ex_o} !== 2'b00) begin errors++; $display("FAIL halt_flush got %b want 00", {bus.flush_if_id_o, bus.flush_id_ex_o}); end
      checks++; if (bus.redirect_cnt_o !== 4'd0) begin errors++; $display("FAIL halt_cnt got %0d want 0", bus.redirect_cnt_o); end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.next_pc_o, bus.flush_if_id_o, bus.flush_id_ex_o, bus.halted_o, bus.redirect_cnt_o} !== '0) begin errors++; $display("FAIL halt_reset outputs not cleared, halted %b next_pc %0d", bus.halted_o, bus.next_pc_o); end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    bus.pc_i = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_branch();
    test_jump_stall();
    test_jump_and_branch();
    test_back_to_back();
    test_random();
    test_reset_mid_flush();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
